// File: rtl/md_sched_if.sv
// Handshake and control bundle between the E/D pipeline stages, the hazard unit
// and the multiply/divide sequencer.
interface md_sched_if;
  logic       start_E;
  logic [1:0] md_op_E;
  logic       md_use_D;
  logic       stall_data;
  logic       busy;
  logic       done;
  logic       hilo_we;
  logic [1:0] op_q;
  logic       en_PC;
  logic       en_FD;
  logic       clr_DE;
  logic       err;

  modport master (
    output start_E, md_op_E, md_use_D, stall_data,
    input  busy, done, hilo_we, op_q, en_PC, en_FD, clr_DE, err
  );

  modport slave (
    input  start_E, md_op_E, md_use_D, stall_data,
    output busy, done, hilo_we, op_q, en_PC, en_FD, clr_DE, err
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: counts the fixed MDU latency, strobes the HI/LO
// write and merges the MDU stall into the pipeline enable/bubble controls.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_lat_q, op_lat_d;
  logic       err_q, err_d;
  logic       busy_w;
  logic       stall_md;
  logic       stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_lat_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_lat_q <= op_lat_d;
      err_q    <= err_d;
    end
  end

  // Loading N-1 and leaving RUN on cnt==0 keeps RUN exactly N cycles long.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_lat_d = op_lat_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_E) begin
          state_d  = RUN;
          op_lat_d = bus.md_op_E;
          cnt_d    = bus.md_op_E[1] ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (bus.start_E) begin
          err_d = 1'b1;
        end
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_w      = (state_q == RUN);
  assign bus.busy    = busy_w;
  assign bus.done    = (state_q == DONE);
  assign bus.hilo_we = (state_q == DONE);
  assign bus.op_q    = op_lat_q;
  assign bus.err     = err_q;

  // DONE is deliberately not a stall: a HI/LO reader in D enters E after the write edge.
  assign stall_md   = bus.md_use_D & (bus.start_E | busy_w);
  assign stall      = stall_md | bus.stall_data;
  assign bus.en_PC  = ~stall;
  assign bus.en_FD  = ~stall;
  assign bus.clr_DE = stall;

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: fixed vector table, directed multi-cycle sequences and
// randomized traffic against a timeline-based reference model.
module tb_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sched_if mif();

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an accepted op occupies a window of absolute cycles.
  int         t       = 0;
  int         run_lo  = -100;
  int         run_hi  = -100;
  int         done_at = -100;
  logic [1:0] m_op    = 2'b00;
  logic       m_err   = 1'b0;

  logic       ob_busy, ob_done, ob_en, ob_err;
  logic [1:0] ob_op;

  typedef struct {
    logic       s;
    logic [1:0] op;
    logic       u;
    logic       sd;
    logic       busy;
    logic       done;
    logic [1:0] opq;
    logic       en;
    logic       clr;
    logic       err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %b, expected %b", nm, t, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %b, expected %b", nm, t, act, exp);
    end
  endtask

  task automatic model_reset();
    run_lo  = -100;
    run_hi  = -100;
    done_at = -100;
    m_op    = 2'b00;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic [1:0] op);
    int n;
    if (s) begin
      if (t >= run_lo && t <= run_hi) begin
        m_err = 1'b1;
      end else begin
        m_op    = op;
        n       = op[1] ? DC : MC;
        run_lo  = t + 1;
        run_hi  = t + n;
        done_at = t + n + 1;
      end
    end
  endtask

  // One pipeline cycle: drive, sample on the falling edge, compare with the model.
  task automatic cyc(input logic s, input logic [1:0] op, input logic u,
                     input logic sd, input logic rp);
    logic m_busy, m_done, m_stall;
    mif.start_E    = s;
    mif.md_op_E    = op;
    mif.md_use_D   = u;
    mif.stall_data = sd;
    if (rp) begin
      reset = 1'b0;
      model_reset();
    end
    @(negedge clk);
    m_busy  = (t >= run_lo && t <= run_hi);
    m_done  = (t == done_at);
    m_stall = (u & (s | m_busy)) | sd;
    chk1("busy",    mif.busy,    m_busy);
    chk1("done",    mif.done,    m_done);
    chk1("hilo_we", mif.hilo_we, m_done);
    chk2("op_q",    mif.op_q,    m_op);
    chk1("en_PC",   mif.en_PC,   ~m_stall);
    chk1("en_FD",   mif.en_FD,   ~m_stall);
    chk1("clr_DE",  mif.clr_DE,  m_stall);
    chk1("err",     mif.err,     m_err);
    ob_busy = mif.busy;
    ob_done = mif.done;
    ob_en   = mif.en_PC;
    ob_err  = mif.err;
    ob_op   = mif.op_q;
    if (rp) begin
      #2 reset = 1'b1;
    end
    model_edge(s, op);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n, input logic u);
    for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, u, 1'b0, 1'b0);
  endtask

  initial begin
    logic saw_done;

    tbl[0] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};

    reset          = 1'b0;
    mif.start_E    = 1'b0;
    mif.md_op_E    = 2'b00;
    mif.md_use_D   = 1'b0;
    mif.stall_data = 1'b0;

    // Reset state
    @(negedge clk);
    chk1("rst_busy",    mif.busy,    1'b0);
    chk1("rst_done",    mif.done,    1'b0);
    chk1("rst_hilo_we", mif.hilo_we, 1'b0);
    chk2("rst_op_q",    mif.op_q,    2'b00);
    chk1("rst_err",     mif.err,     1'b0);
    chk1("rst_en_PC",   mif.en_PC,   1'b1);
    chk1("rst_en_FD",   mif.en_FD,   1'b1);
    chk1("rst_clr_DE",  mif.clr_DE,  1'b0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: mult latency then stall_data merge in IDLE
    for (int i = 0; i < 10; i++) begin
      mif.start_E    = tbl[i].s;
      mif.md_op_E    = tbl[i].op;
      mif.md_use_D   = tbl[i].u;
      mif.stall_data = tbl[i].sd;
      @(negedge clk);
      chk1("tbl_busy",    mif.busy,    tbl[i].busy);
      chk1("tbl_done",    mif.done,    tbl[i].done);
      chk1("tbl_hilo_we", mif.hilo_we, tbl[i].done);
      chk2("tbl_op_q",    mif.op_q,    tbl[i].opq);
      chk1("tbl_en_PC",   mif.en_PC,   tbl[i].en);
      chk1("tbl_en_FD",   mif.en_FD,   tbl[i].en);
      chk1("tbl_clr_DE",  mif.clr_DE,  tbl[i].clr);
      chk1("tbl_err",     mif.err,     tbl[i].err);
      @(posedge clk);
      #1;
      t++;
    end

    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // divu with a HI/LO reader waiting in D
    cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    chk1("divu_stall_c0", ob_en, 1'b0);
    idle(10, 1'b1);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk1("divu_done_c11", ob_done, 1'b1);
    chk1("divu_release",  ob_en,   1'b1);
    chk2("divu_op_q",     ob_op,   2'b11);
    idle(2, 1'b0);

    // Back-to-back mult: second start accepted in DONE
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    chk1("b2b_done_c6", ob_done, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk1("b2b_busy_c7", ob_busy, 1'b1);
    chk2("b2b_op_q",    ob_op,   2'b01);
    idle(4, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk1("b2b_done_c12", ob_done, 1'b1);
    chk1("b2b_err",      ob_err,  1'b0);
    idle(1, 1'b0);

    // Illegal start during a running div
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk1("viol_err_c4",  ob_err, 1'b1);
    chk2("viol_op_kept", ob_op,  2'b10);
    idle(6, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk1("viol_done_c11", ob_done, 1'b1);
    chk1("viol_err_stky", ob_err,  1'b1);
    idle(1, 1'b0);

    // Reset pulse in the middle of a div
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk1("abort_busy", ob_busy, 1'b0);
    chk1("abort_err",  ob_err,  1'b0);
    saw_done = 1'b0;
    for (int k = 5; k <= 15; k++) begin
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      saw_done = saw_done | ob_done;
    end
    chk1("abort_no_done", saw_done, 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic       rs, ru, rsd, rrp;
      logic [1:0] rop;
      rs  = ($urandom_range(3) == 0);
      rop = 2'($urandom_range(3));
      ru  = 1'($urandom_range(1));
      rsd = ($urandom_range(4) == 0);
      rrp = ($urandom_range(79) == 0);
      cyc(rs, rop, ru, rsd, rrp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
